// File: rtl/uart_rx_oversample_if.sv
// Byte-stream port of the oversampling UART receiver: held byte, status flags
// and the valid/ready handshake toward the consumer.
interface uart_rx_oversample_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              ready_in;
    logic              parity_ok;
    logic              frame_err;
    logic              break_det;
    logic              overrun;

    modport master (
        output data_out, valid_out, parity_ok, frame_err, break_det, overrun,
        input  ready_in
    );

    modport slave (
        input  data_out, valid_out, parity_ok, frame_err, break_det, overrun,
        output ready_in
    );
endinterface

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling UART receiver: start qualification, optional even parity,
// 1/2 stop bits, framing/break detection and a one-entry holding register.
module uart_rx_oversample #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 12,
    parameter int OVS    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             rx_en,
    input  logic             parity_sel,
    input  logic             stop_sel,
    input  logic [DIV_W-1:0] baud_divisor,
    uart_rx_oversample_if.master rx_bus
);
    localparam int SAMP_W = $clog2(OVS);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [SAMP_W-1:0] SAMP_ONE = SAMP_W'(1);
    localparam logic [SAMP_W-1:0] HALF     = SAMP_W'(OVS / 2 - 1);
    localparam logic [SAMP_W-1:0] LAST     = SAMP_W'(OVS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE} state_t;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_ONE : d;
    endfunction

    function automatic logic is_break(input logic [DATA_W-1:0] d, input logic ferr,
                                      input logic pen, input logic pbit);
        return (d == '0) && ferr && (!pen || !pbit);
    endfunction

    state_t            state;
    logic              rx_s1, rx_s2;
    logic [DIV_W-1:0]  div_l, div_cnt;
    logic [SAMP_W-1:0] samp_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              par_l, stop_l, par_bit, stop1_bit;

    logic              commit_p1, perr_p1, ferr_p1, brk_p1;
    logic [DATA_W-1:0] byte_p1;

    logic [DATA_W-1:0] data_q;
    logic              valid_q, pok_q, ferr_q, brk_q, overrun_q;

    logic tick, bit_end, frame_end, ferr_now;

    assign tick      = (div_cnt == div_l - DIV_ONE);
    assign bit_end   = tick && (samp_cnt == LAST);
    assign frame_end = bit_end && ((state == STOP1 && !stop_l) || state == STOP2);
    // Either stop sample being low is a framing error.
    assign ferr_now  = !rx_s2 || (state == STOP2 && !stop1_bit);

    // Stage p0: synchroniser, tick generator and frame FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            state     <= IDLE;
            div_l     <= '0;
            div_cnt   <= '0;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            par_l     <= 1'b0;
            stop_l    <= 1'b0;
            par_bit   <= 1'b0;
            stop1_bit <= 1'b0;
            commit_p1 <= 1'b0;
            perr_p1   <= 1'b0;
            ferr_p1   <= 1'b0;
            brk_p1    <= 1'b0;
            byte_p1   <= '0;
        end else begin
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            commit_p1 <= 1'b0;
            if (state != IDLE && state != WAIT_IDLE) begin
                if (tick) begin
                    div_cnt  <= '0;
                    samp_cnt <= (samp_cnt == LAST) ? '0 : samp_cnt + SAMP_ONE;
                end else begin
                    div_cnt <= div_cnt + DIV_ONE;
                end
            end
            if (!rx_en) begin
                state    <= IDLE;
                div_cnt  <= '0;
                samp_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: if (!rx_s2) begin
                        state    <= START;
                        par_l    <= parity_sel;
                        stop_l   <= stop_sel;
                        div_l    <= clamp_div(baud_divisor);
                        div_cnt  <= '0;
                        samp_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                    START: if (tick && samp_cnt == HALF) begin
                        samp_cnt <= '0;
                        state    <= rx_s2 ? IDLE : DATA;
                    end
                    DATA: if (bit_end) begin
                        shift <= {rx_s2, shift[DATA_W-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_l ? PARITY : STOP1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end
                    PARITY: if (bit_end) begin
                        par_bit <= rx_s2;
                        state   <= STOP1;
                    end
                    STOP1: if (bit_end && stop_l) begin
                        stop1_bit <= rx_s2;
                        state     <= STOP2;
                    end
                    WAIT_IDLE: if (rx_s2) state <= IDLE;
                    default: ;
                endcase
                if (frame_end) begin
                    commit_p1 <= 1'b1;
                    byte_p1   <= shift;
                    perr_p1   <= par_l && (par_bit != ^shift);
                    ferr_p1   <= ferr_now;
                    brk_p1    <= is_break(shift, ferr_now, par_l, par_bit);
                    state     <= ferr_now ? WAIT_IDLE : IDLE;
                end
            end
        end
    end

    // Stage p1: holding register and consumer handshake
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            pok_q     <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (valid_q && rx_bus.ready_in) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (commit_p1) begin
                // A same-edge handshake frees the slot, so the new frame loads.
                if (!valid_q || rx_bus.ready_in) begin
                    data_q  <= byte_p1;
                    pok_q   <= !perr_p1;
                    ferr_q  <= ferr_p1;
                    brk_q   <= brk_p1;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign rx_bus.data_out  = data_q;
    assign rx_bus.valid_out = valid_q;
    assign rx_bus.parity_ok = pok_q;
    assign rx_bus.frame_err = ferr_q;
    assign rx_bus.break_det = brk_q;
    assign rx_bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: directed frames plus randomized frames checked
// against a line-level model of what each frame should decode to.
module tb_uart_rx_oversample;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        rx_en = 1'b1;
    logic        parity_sel = 1'b0;
    logic        stop_sel = 1'b0;
    logic [11:0] baud_divisor = 12'd4;

    int n_checks = 0;
    int n_fail = 0;
    int bit_clks = 64;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    logic prev_v = 1'b0;

    uart_rx_oversample_if #(.DATA_W(8)) bif ();

    uart_rx_oversample #(.DATA_W(8), .DIV_W(12), .OVS(16)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rx_en(rx_en),
        .parity_sel(parity_sel), .stop_sel(stop_sel),
        .baud_divisor(baud_divisor), .rx_bus(bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bif.valid_out === 1'b1 && prev_v !== 1'b1) rise_cyc = cyc;
        prev_v = bif.valid_out;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_div(input logic [11:0] d);
        baud_divisor = d;
        bit_clks = ((d == 0) ? 1 : int'(d)) * 16;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (bit_clks) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * bit_clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pb,
                              input logic s2en, input logic st1, input logic st2);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pb);
        drive_bit(st1);
        if (s2en) drive_bit(st2);
        rx = 1'b1;
    endtask

    // Expected decode of one frame, straight from the line-level rules.
    task automatic check_frame(input string tag, input logic [7:0] d, input logic pen,
                               input logic pb, input logic s2en, input logic st1, input logic st2);
        logic ferr, pok, brk;
        ferr = !st1 || (s2en && !st2);
        pok  = !pen || (pb == ^d);
        brk  = (d == 8'h00) && ferr && (!pen || !pb);
        check_val({tag, "_valid"}, bif.valid_out, 1);
        check_val({tag, "_data"}, bif.data_out, d);
        check_val({tag, "_parity_ok"}, bif.parity_ok, pok);
        check_val({tag, "_frame_err"}, bif.frame_err, ferr);
        check_val({tag, "_break"}, bif.break_det, brk);
    endtask

    task automatic consume(input string tag);
        bif.ready_in = 1'b1;
        @(negedge clk);
        bif.ready_in = 1'b0;
        check_val({tag, "_valid_cleared"}, bif.valid_out, 0);
        check_val({tag, "_overrun_cleared"}, bif.overrun, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic pen, pb, s2en, st1, st2;
        int lat, nom;
        bif.ready_in = 1'b0;
        repeat (4) @(negedge clk);
        check_val("rst_valid", bif.valid_out, 0);
        check_val("rst_data", bif.data_out, 0);
        check_val("rst_parity_ok", bif.parity_ok, 0);
        check_val("rst_frame_err", bif.frame_err, 0);
        check_val("rst_break", bif.break_det, 0);
        check_val("rst_overrun", bif.overrun, 0);
        reset = 1'b1;
        set_div(12'd4);
        idle_bits(1);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        check_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        lat = rise_cyc - start_cyc;
        nom = bit_clks / 2 + 9 * bit_clks;
        check_val("a5_latency_window", (lat >= nom && lat <= nom + 8), 1);
        consume("a5");

        parity_sel = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        check_frame("par_bad", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        consume("par_bad");
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        check_frame("par_good", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        consume("par_good");
        parity_sel = 1'b0;

        rx = 1'b0;
        repeat (24) @(negedge clk);
        idle_bits(3);
        check_val("glitch_no_valid", bif.valid_out, 0);

        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        check_val("ovr_data", bif.data_out, 8'h11);
        check_val("ovr_flag", bif.overrun, 1);
        consume("ovr");

        rx = 1'b0;
        repeat (11 * bit_clks) @(negedge clk);
        check_frame("brk", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        consume("brk");
        repeat (bit_clks) @(negedge clk);
        check_val("brk_low_no_retrigger", bif.valid_out, 0);
        idle_bits(2);
        check_val("brk_high_no_frame", bif.valid_out, 0);

        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx_en = 1'b0;
        for (int i = 0; i < 7; i++) drive_bit(i[0]);
        rx = 1'b1;
        rx_en = 1'b1;
        idle_bits(2);
        check_val("abort_no_valid", bif.valid_out, 0);

        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        check_val("pre_rst_valid", bif.valid_out, 1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        reset = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        check_val("midrst_valid", bif.valid_out, 0);
        check_val("midrst_data", bif.data_out, 0);
        check_val("midrst_parity_ok", bif.parity_ok, 0);
        reset = 1'b1;
        idle_bits(2);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        check_frame("post_rst", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        consume("post_rst");

        for (int k = 0; k < 14; k++) begin
            set_div(12'($urandom_range(0, 4)));
            pen  = 1'($urandom_range(0, 1));
            s2en = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            pb   = (^d) ^ ($urandom_range(0, 3) == 0);
            st1  = ($urandom_range(0, 4) != 0);
            st2  = ($urandom_range(0, 4) != 0);
            if (k == 0) begin
                d = 8'h00;
                pb = 1'b0;
                st1 = 1'b0;
                st2 = 1'b0;
            end
            parity_sel = pen;
            stop_sel   = s2en;
            idle_bits(1);
            send_frame(d, pen, pb, s2en, st1, st2);
            idle_bits(1);
            check_frame($sformatf("rnd%0d", k), d, pen, pb, s2en, st1, st2);
            consume($sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
